// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_mag_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_mag_comparator_cell.sv
// Single-bit magnitude compare cell used by the serial comparator.
module comparator_1bit (
    input  logic A,
    input  logic B,
    output logic A_greater_B,
    output logic A_less_B,
    output logic A_equal_B
);

    assign A_greater_B = A & ~B;
    assign A_less_B    = ~A & B;
    assign A_equal_B   = ~(A ^ B);

endmodule

// File: rtl/serial_mag_comparator.sv
// MSB-first bit-serial unsigned comparator with early exit on the first differing bit.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_greater_b,
    output logic             a_less_b,
    output logic             a_equal_b
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             busy_q, done_q;
    logic             cell_gt, cell_lt, cell_eq;

    comparator_1bit u_cell (
        .A           (sa_q[WIDTH-1]),
        .B           (sb_q[WIDTH-1]),
        .A_greater_B (cell_gt),
        .A_less_B    (cell_lt),
        .A_equal_B   (cell_eq)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            busy_q  <= (state_d == ST_SHIFT);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CW'(WIDTH - 1);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!cell_eq) begin
                    gt_d    = cell_gt;
                    lt_d    = cell_lt;
                    state_d = ST_DONE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    sa_d  = sa_q << 1;
                    sb_d  = sb_q << 1;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign a_greater_b = gt_q;
    assign a_less_b    = lt_q;
    assign a_equal_b   = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: driver pushes reference results, negedge monitor checks on done.
module tb_serial_mag_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, a_greater_b, a_less_b, a_equal_b;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   j;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .a_greater_b (a_greater_b),
        .a_less_b    (a_less_b),
        .a_equal_b   (a_equal_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: ordering by plain relational compare; latency from the highest differing bit.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
        exp_t         e;
        logic [W-1:0] diff;
        e.gt  = (x > y);
        e.lt  = (x < y);
        e.eq  = (x == y);
        e.acc = acc;
        e.j   = W;
        diff  = x ^ y;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                e.j = W - i;
                break;
            end
        end
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                check("flags_zero_while_busy", {a_greater_b, a_less_b, a_equal_b}, 0);
            end
            check("flags_at_most_one_hot", ($countones({a_greater_b, a_less_b, a_equal_b}) <= 1), 1);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("a_greater_b", a_greater_b, e.gt);
                    check("a_less_b", a_less_b, e.lt);
                    check("a_equal_b", a_equal_b, e.eq);
                    check("done_latency", cyc - e.acc, e.j);
                    check("busy_cycles", busy_cnt, e.j);
                    check("busy_low_at_done", busy, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Wait for the outstanding result, then one more cycle so the DUT is back in IDLE.
    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Issue one request from IDLE; optionally keep start high or poke start while busy.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input bit hold, input bit poke);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge clk);
        #1;
        sb.push_back(model(ta, tb_v, cyc));
        if (!hold) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        if (poke) begin
            @(negedge clk);
            #1;
            start = 1'b1;
            a     = ~ta;
            b     = ta;
            @(negedge clk);
            #1;
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_gt", a_greater_b, 0);
        check("reset_lt", a_less_b, 0);
        check("reset_eq", a_equal_b, 0);

        do_op(8'hA5, 8'h5A, 1'b0, 1'b0);
        do_op(8'h3C, 8'h3D, 1'b0, 1'b0);
        do_op(8'h77, 8'h77, 1'b1, 1'b0);
        do_op(8'h80, 8'h00, 1'b0, 1'b0);
        do_op(8'h3C, 8'h3D, 1'b0, 1'b1);
        do_op(8'h00, 8'h01, 1'b0, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0);

        // Abort an equal compare three edges after it was accepted
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        sb.push_back(model(8'hFF, 8'hFF, cyc));
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flags", {a_greater_b, a_less_b, a_equal_b}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_late_done", done, 0);
        do_op(8'h12, 8'h13, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
